mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  CPU-side initiator for the byte-addressable data RAM (byte/half/word port, mem_u_b_h_w code).
//  Accepts one load/store per valid/ready handshake and drives the RAM port. Misaligned half/word
//  accesses are split into byte beats. Load results are assembled and sign/zero-extended.
//  Sits between the pipeline MEM stage and the data RAM; the pipeline stalls while req_ready=0.
// PARAMETERS
//  ADDR_BITS   7   RAM byte-address width; any byte address with bits [31:ADDR_BITS] set is out of range
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   unit idle, request accepted when req_valid&req_ready
//  req_we       in   1   1=store, 0=load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-aligned
//  req_u_b_h_w  in   3   [2]=unsigned, [1]=word, [0]=half, [1:0]==00 -> byte; [1] dominates [0]
//  rsp_valid    out  1   one-cycle pulse: access complete
//  rsp_rdata    out  32  extended load data (0 for stores and errors), valid with rsp_valid
//  rsp_err      out  1   out-of-range access, valid with rsp_valid
//  ram_addr     out  32  RAM byte address
//  ram_din      out  32  RAM write data
//  ram_we       out  1   RAM write enable; RAM writes on negedge clk of the cycle it is high
//  ram_u_b_h_w  out  3   RAM width code
//  ram_dout     in   32  RAM combinational read data
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we=0, ram_addr=0,
//   ram_din=0, ram_u_b_h_w=0, beat counter=0, assembly register=0. rst mid-access aborts it: no
//   further beats, no rsp_valid; a write beat already issued stays committed.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. req_ready=1 only in IDLE. Request fields are latched on accept.
//  Alignment: word aligned iff addr[1:0]==0, half iff addr[0]==0, byte is always aligned.
//  Aligned: 1 beat; ram_addr=addr, ram_u_b_h_w=code, ram_din=wdata, ram_we=we.
//  Misaligned: N beats (half 2, word 4); beat k drives ram_addr=addr+k, ram_u_b_h_w=3'b100,
//   ram_din[7:0]=wdata byte k, ram_we=we. Beat k of a load captures ram_dout[7:0] into assembly
//   byte k at the posedge ending the beat.
//  Range check at accept: err if any of addr..addr+size-1 has bits [31:ADDR_BITS] set. On err,
//   ACCESS lasts 1 cycle with ram_we=0 and ram_u_b_h_w=0, then RESP with rsp_err=1 and rsp_rdata=0.
//  Latency from the accept edge: aligned or err rsp_valid in cycle +2; misaligned half in +3;
//   misaligned word in +5. Next accept possible in the cycle after RESP.
//  Outside ACCESS, ram_we=0 and ram_u_b_h_w=0. ram_addr and ram_din hold their last values.
//  Load extension (aligned or assembled): byte -> [7:0] extended by bit 7; half -> [15:0] extended
//   by bit 15; unsigned bit set -> zero-fill; word -> unchanged. Aligned RAM data is re-extended the
//   same way, so the result is identical on either path.
//  rsp_rdata and rsp_err are registered; they hold their value after RESP until the next RESP.
//  A req_valid without accept (unit busy) is ignored. The requester must keep the request stable.
// STRUCTURE
//  Shared package mem_pkg: width codes MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_U=3'b100;
//   FSM state enum {IDLE, ACCESS, RESP}; function size_of(code) returning 1, 2 or 4.
//  Sub-module load_extend (combinational): code + raw 32-bit value -> extended 32-bit value.
//   Shared by the aligned and assembled paths.
// TESTING
//  1 Aligned sw 0x11223344 @0x10, then lw @0x10 -> ram_we for 1 cycle; rsp_rdata=0x11223344 at +2.
//  2 Misaligned sw 0xAABBCCDD @0x21 -> 4 beats to 0x21..0x24 with bytes DD,CC,BB,AA;
//    lw @0x21 -> rsp_rdata=0xAABBCCDD at +5.
//  3 Byte 0x80 @0x05: lb -> 0xFFFFFF80; lbu -> 0x00000080. Half 0x8001 @0x07 (misaligned):
//    lh -> 0xFFFF8001 at +3; lhu -> 0x00008001.
//  4 sw @0x7E (crosses 0x80) -> rsp_err=1, ram_we never high, RAM contents unchanged;
//    lw @0x100 -> rsp_err=1, rsp_rdata=0.
//  5 Back-to-back: req_valid held over 3 requests -> req_ready low during ACCESS/RESP;
//    exactly 3 rsp_valid pulses, in order.
//  6 rst asserted during beat 2 of a misaligned sw -> beats 0-1 written, bytes 2-3 untouched;
//    no rsp_valid; next cycle IDLE with req_ready=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Width codes, FSM states and access-size helper shared by the memory access unit.
// Width code bits: [2] unsigned, [1] word, [0] half; word dominates half.
package mem_pkg;

  localparam logic [2:0] MEM_B = 3'b000;
  localparam logic [2:0] MEM_H = 3'b001;
  localparam logic [2:0] MEM_W = 3'b010;
  localparam logic [2:0] MEM_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Access size in bytes; 3'b011 is treated as a word.
  function automatic logic [2:0] size_of(input logic [2:0] code);
    case (code & ~MEM_U)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      MEM_W:   return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension: byte/half sign- or zero-extended, word passed through.
// Used for both the direct RAM path and the byte-assembled misaligned path.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  code,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic sgn;

  assign sgn = ((code & MEM_U) == MEM_B);

  always_comb begin
    ext = raw;
    case (size_of(code))
      3'd1:    ext = {{24{raw[7] & sgn}}, raw[7:0]};
      3'd2:    ext = {{16{raw[15] & sgn}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte RAM; aligned/err respond at +2, misaligned half +3, word +5.
// req_ready is high only in IDLE, so the pipeline stalls for the whole access and response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_u_b_h_w,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_u_b_h_w,
  input  logic [31:0] ram_dout
);

  state_t      state_q, state_d;
  logic        we_q, err_q, mis_q;
  logic [31:0] addr_q, wdata_q, asm_q, asm_next, ext_raw, ext_data;
  logic [2:0]  code_q, req_size;
  logic [1:0]  beat_q, beat_nx, last_q;
  logic [31:0] req_end;
  logic        req_err, req_mis, last_beat, drive;

  // Range is contiguous from 0, so checking the first and last byte covers the span.
  assign req_size = size_of(req_u_b_h_w);
  assign req_end  = req_addr + 32'(req_size) - 32'd1;
  assign req_err  = (|(req_addr >> ADDR_BITS)) | (|(req_end >> ADDR_BITS));
  assign req_mis  = (req_size == 3'd4) ? (req_addr[1:0] != 2'b00) :
                    (req_size == 3'd2) ? req_addr[0] : 1'b0;

  assign beat_nx   = beat_q + 2'd1;
  assign last_beat = err_q || (beat_q == last_q);

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  // rst blanks the RAM strobes combinationally so a beat in the reset cycle is never written.
  assign drive       = (state_q == ACCESS) && !err_q && !rst;
  assign ram_we      = drive && we_q;
  assign ram_u_b_h_w = drive ? (mis_q ? MEM_U : code_q) : MEM_B;

  always_comb begin
    asm_next = asm_q;
    asm_next[{beat_q, 3'b000} +: 8] = ram_dout[7:0];
  end

  assign ext_raw = mis_q ? asm_next : ram_dout;

  load_extend u_load_extend (
    .code (code_q),
    .raw  (ext_raw),
    .ext  (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  if (last_beat) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      code_q    <= '0;
      beat_q    <= '0;
      last_q    <= '0;
      asm_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            err_q   <= req_err;
            mis_q   <= req_mis;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            code_q  <= req_u_b_h_w;
            beat_q  <= '0;
            last_q  <= req_mis ? 2'(req_size - 3'd1) : 2'd0;
            asm_q   <= '0;
            if (!req_err) begin
              ram_addr <= req_addr;
              ram_din  <= req_mis ? {24'h0, req_wdata[7:0]} : req_wdata;
            end
          end
        end
        ACCESS: begin
          if (mis_q) asm_q <= asm_next;
          if (last_beat) begin
            rsp_err   <= err_q;
            rsp_rdata <= (err_q || we_q) ? 32'h0 : ext_data;
          end else begin
            beat_q   <= beat_nx;
            ram_addr <= addr_q + 32'(beat_nx);
            ram_din  <= {24'h0, wdata_q[{beat_nx, 3'b000} +: 8]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised and directed bench for mem_access_unit against a byte-array reference model.
// The bench also models the 128-byte data RAM (negedge write, combinational read).
module tb_mem_access_unit;

  localparam int AB  = 7;
  localparam int MSZ = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_u_b_h_w;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic        ram_we;
  logic [2:0]  ram_u_b_h_w;

  logic [7:0]  mem  [MSZ];
  logic [7:0]  gold [MSZ];
  int          n_vec = 0;
  int          n_err = 0;
  int          rsp_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(AB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_u_b_h_w (req_u_b_h_w),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_u_b_h_w (ram_u_b_h_w),
    .ram_dout    (ram_dout)
  );

  // RAM model: returns four bytes from the address regardless of width, so the unit must extend.
  always_comb begin
    for (int i = 0; i < 4; i++) ram_dout[8*i +: 8] = mem[7'(ram_addr[6:0] + 7'(i))];
  end

  initial begin
    int sz;
    for (int i = 0; i < MSZ; i++) mem[i] = 8'(i * 29 + 3);
    forever begin
      @(negedge clk);
      if (ram_we) begin
        sz = ram_u_b_h_w[1] ? 4 : (ram_u_b_h_w[0] ? 2 : 1);
        for (int i = 0; i < sz; i++) mem[7'(ram_addr[6:0] + 7'(i))] = ram_din[8*i +: 8];
      end
    end
  end

  always @(negedge clk) if (rsp_valid) rsp_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int size_ref(input logic [2:0] c);
    return c[1] ? 4 : (c[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] ext_ref(input logic [2:0] c, input logic [31:0] raw);
    int     sz;
    longint m, v;
    sz = size_ref(c);
    if (sz == 4) return raw;
    m = (longint'(1) << (8 * sz)) - 1;
    v = longint'(raw) & m;
    if (!c[2] && ((raw >> (8 * sz - 1)) & 32'd1) != 0) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] code, input bit keep);
    int          sz, beats, lat, cyc, w;
    bit          err, mis, got;
    logic [31:0] raw, exp_rd, exp_din;
    sz    = size_ref(code);
    err   = (longint'(addr) + longint'(sz)) > MSZ;
    mis   = (addr % sz) != 0;
    beats = (mis && !err) ? sz : 1;
    lat   = beats + 1;
    raw   = 32'h0;
    if (!err) for (int i = 0; i < sz; i++) raw = raw | (32'(gold[addr + i]) << (8 * i));
    exp_rd = (err || we) ? 32'h0 : ext_ref(code, raw);
    if (we && !err) for (int i = 0; i < sz; i++) gold[addr + i] = wdata[8*i +: 8];

    req_valid   = 1'b1;
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wdata;
    req_u_b_h_w = code;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready", req_ready, 1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;

    cyc = 1;
    got = 0;
    while (!got && cyc <= 8) begin
      @(negedge clk);
      if (cyc < lat) begin
        check("ctl", {ram_we, ram_u_b_h_w}, err ? 4'b0 : {we, mis ? 3'b100 : code});
        if (!err) check("addr", ram_addr, addr + (mis ? 32'(cyc - 1) : 32'h0));
        if (we && !err) begin
          exp_din = mis ? ((wdata >> (8 * (cyc - 1))) & 32'hFF) : wdata;
          check("din", mis ? {24'h0, ram_din[7:0]} : ram_din, exp_din);
        end
        check("busy", req_ready, 0);
      end else begin
        check("idle_ctl", {ram_we, ram_u_b_h_w}, 4'b0);
      end
      if (rsp_valid) got = 1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check($sformatf("lat@%0h", addr), got ? cyc : 0, lat);
    if (got) begin
      check($sformatf("rdata@%0h", addr), rsp_rdata, exp_rd);
      check($sformatf("err@%0h", addr), rsp_err, err);
      check("resp_busy", req_ready, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          c0, r;
    logic [31:0] a;
    for (int i = 0; i < MSZ; i++) gold[i] = 8'(i * 29 + 3);
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_u_b_h_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_ram_code", ram_u_b_h_w, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // aligned word, misaligned word
    run_req(1, 32'h10, 32'h11223344, 3'b010, 0);
    run_req(0, 32'h10, 32'h0,        3'b010, 0);
    run_req(1, 32'h21, 32'hAABBCCDD, 3'b010, 0);
    run_req(0, 32'h21, 32'h0,        3'b010, 0);
    check("direct_aw", rsp_rdata, 32'hAABBCCDD);
    // byte and misaligned half, signed and unsigned
    run_req(1, 32'h05, 32'h80,   3'b000, 0);
    run_req(0, 32'h05, 32'h0,    3'b000, 0);
    check("direct_lb", rsp_rdata, 32'hFFFFFF80);
    run_req(0, 32'h05, 32'h0,    3'b100, 0);
    run_req(1, 32'h07, 32'h8001, 3'b001, 0);
    run_req(0, 32'h07, 32'h0,    3'b001, 0);
    check("direct_lh", rsp_rdata, 32'hFFFF8001);
    run_req(0, 32'h07, 32'h0,    3'b101, 0);
    // out of range
    run_req(1, 32'h7E,  32'hDEADBEEF, 3'b010, 0);
    run_req(0, 32'h100, 32'h0,        3'b010, 0);
    // back-to-back with req_valid held
    c0 = rsp_cnt;
    run_req(1, 32'h0C, 32'h01020304, 3'b010, 1);
    run_req(0, 32'h0D, 32'h0,        3'b001, 1);
    run_req(0, 32'h0F, 32'h0,        3'b100, 0);
    check("b2b_pulses", rsp_cnt - c0, 3);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom_range(120, 400);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, MSZ - 1);
      run_req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
              (i != 79) && ($urandom_range(0, 1) == 1));
    end

    // reset during beat 2 of a misaligned store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h31; req_wdata = 32'h55667788;
    req_u_b_h_w = 3'b010;
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c0 = rsp_cnt;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", ram_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", req_ready, 1);
    check("abort_rdata", rsp_rdata, 0);
    repeat (3) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - c0, 0);
    gold[32'h31] = 8'h88;
    gold[32'h32] = 8'h77;
    @(posedge clk);
    #1;
    run_req(0, 32'h31, 32'h0, 3'b010, 0);

    for (int i = 0; i < MSZ; i++) check($sformatf("mem[%0h]", i), mem[i], gold[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
